// File: rtl/prog_loader.sv
// prog_loader: serial program loader for the 16x8 RAM programming port.
// It receives 8N1 UART bytes on rx. A SYNC_BYTE starts a load, and the
// next 16 bytes are written to RAM addresses 0..15 with one-cycle
// prog_mode strobes. The CPU is held halted while a load is in progress.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx         UART serial input (idle high, asynchronous to clk)
//   prog_mode  one-cycle RAM write strobe
//   prog_addr  RAM write address (held between strobes)
//   prog_data  RAM write data (held between strobes)
//   cpu_halt   high from sync-byte acceptance until the load completes or aborts
//   load_done  one-cycle pulse after the 16th write
//   load_err   sticky framing-error flag, cleared by the next sync byte
//   busy       high while the UART receiver is not idle
module prog_loader #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'h55
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       prog_mode,
  output logic [3:0] prog_addr,
  output logic [7:0] prog_data,
  output logic       cpu_halt,
  output logic       load_done,
  output logic       load_err,
  output logic       busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_MID  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE} ld_state_e;

  logic            rx_meta_q, rx_s_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  ld_state_e       ld_state_q, ld_state_d;
  logic [3:0]      wr_addr_q, wr_addr_d;
  logic            prog_mode_q, prog_mode_d;
  logic [3:0]      prog_addr_q, prog_addr_d;
  logic [7:0]      prog_data_q, prog_data_d;
  logic            cpu_halt_q, cpu_halt_d;
  logic            load_done_q, load_done_d;
  logic            load_err_q, load_err_d;

  // State registers for both FSMs, their datapath and the synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_state_q   <= RX_IDLE;
      tick_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ld_state_q   <= L_IDLE;
      wr_addr_q    <= '0;
      prog_mode_q  <= 1'b0;
      prog_addr_q  <= '0;
      prog_data_q  <= '0;
      cpu_halt_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      rx_state_q   <= rx_state_d;
      tick_q       <= tick_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      ld_state_q   <= ld_state_d;
      wr_addr_q    <= wr_addr_d;
      prog_mode_q  <= prog_mode_d;
      prog_addr_q  <= prog_addr_d;
      prog_data_q  <= prog_data_d;
      cpu_halt_q   <= cpu_halt_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  // Receiver next state
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (!rx_s_q) rx_state_d = RX_START;
      // A line that is high again by mid start bit was a glitch
      RX_START: if (tick_q == TICK_MID) rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_q == TICK_LAST && bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
      RX_STOP:  if (tick_q == TICK_LAST) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver datapath: counters, shift register, byte/error pulses
  always_comb begin
    tick_d       = tick_q + 1'b1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        tick_d    = '0;
        bit_cnt_d = '0;
      end
      RX_START: if (tick_q == TICK_MID) tick_d = '0;
      RX_DATA: if (tick_q == TICK_LAST) begin
        tick_d    = '0;
        shift_d   = {rx_s_q, shift_q[7:1]};  // LSB arrives first
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
      RX_STOP: if (tick_q == TICK_LAST) begin
        tick_d       = '0;
        byte_valid_d = rx_s_q;
        frame_err_d  = !rx_s_q;
      end
      default: tick_d = '0;
    endcase
  end

  // Loader next state
  always_comb begin
    ld_state_d = ld_state_q;
    case (ld_state_q)
      L_IDLE: if (byte_valid_q && shift_q == SYNC_BYTE) ld_state_d = L_LOAD;
      L_LOAD: begin
        if (byte_valid_q && wr_addr_q == 4'd15) ld_state_d = L_DONE;
        else if (frame_err_q)                   ld_state_d = L_IDLE;
      end
      L_DONE:  ld_state_d = L_IDLE;
      default: ld_state_d = L_IDLE;
    endcase
  end

  // Loader outputs; address and data hold their last values between strobes
  always_comb begin
    wr_addr_d   = wr_addr_q;
    prog_mode_d = 1'b0;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    cpu_halt_d  = cpu_halt_q;
    load_done_d = 1'b0;
    load_err_d  = load_err_q;
    case (ld_state_q)
      L_IDLE: begin
        if (byte_valid_q && shift_q == SYNC_BYTE) begin
          cpu_halt_d = 1'b1;
          wr_addr_d  = '0;
          load_err_d = 1'b0;
        end else if (frame_err_q) begin
          load_err_d = 1'b1;
        end
      end
      L_LOAD: begin
        if (byte_valid_q) begin
          prog_mode_d = 1'b1;
          prog_addr_d = wr_addr_q;
          prog_data_d = shift_q;
          wr_addr_d   = wr_addr_q + 1'b1;
        end else if (frame_err_q) begin
          load_err_d = 1'b1;
          cpu_halt_d = 1'b0;
        end
      end
      L_DONE: begin
        load_done_d = 1'b1;
        cpu_halt_d  = 1'b0;
      end
      default: ;
    endcase
  end

  assign prog_mode = prog_mode_q;
  assign prog_addr = prog_addr_q;
  assign prog_data = prog_data_q;
  assign cpu_halt  = cpu_halt_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;
  assign busy      = (rx_state_q != RX_IDLE);

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  localparam int         CPB  = 4;
  localparam logic [7:0] SYNC = 8'h55;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       prog_mode;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       cpu_halt, load_done, load_err, busy;

  int n_checks = 0;
  int n_errors = 0;

  prog_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .prog_mode(prog_mode), .prog_addr(prog_addr), .prog_data(prog_data),
    .cpu_halt(cpu_halt), .load_done(load_done), .load_err(load_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: loader behaviour per received byte
  bit         m_loading = 0;
  int         m_addr    = 0;
  bit         m_err     = 0;
  int         exp_done  = 0;
  int         exp_addr[$];
  int         exp_data[$];
  logic [7:0] exp_ram[16];

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!m_loading) begin
      if (!ok) m_err = 1;
      else if (b == SYNC) begin
        m_loading = 1; m_addr = 0; m_err = 0;
      end
    end else if (!ok) begin
      m_err = 1; m_loading = 0;
    end else begin
      exp_addr.push_back(m_addr);
      exp_data.push_back(int'(b));
      exp_ram[m_addr] = b;
      m_addr++;
      if (m_addr == 16) begin
        m_loading = 0; exp_done++;
      end
    end
  endtask

  // Observed side: RAM model fed by the strobes
  int         obs_addr[$];
  int         obs_data[$];
  int         obs_done = 0;
  logic [7:0] tb_ram[16];
  logic       prev_pm  = 1'b0;
  logic       prev_a15 = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (prog_mode) begin
        chk("strobe_width", 32'(prev_pm), 32'd0);
        chk("halt_during_write", 32'(cpu_halt), 32'd1);
        obs_addr.push_back(int'(prog_addr));
        obs_data.push_back(int'(prog_data));
        tb_ram[prog_addr] = prog_data;
      end
      if (load_done) begin
        obs_done++;
        chk("done_after_last_write", 32'(prev_a15), 32'd1);
        chk("halt_low_at_done", 32'(cpu_halt), 32'd0);
      end
      prev_pm  = prog_mode;
      prev_a15 = prog_mode && (prog_addr == 4'd15);
    end else begin
      prev_pm  = 1'b0;
      prev_a15 = 1'b0;
    end
  end

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    model_byte(b, ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(ok);
    rx = 1'b1;
    if (!ok) repeat (20 * CPB) @(posedge clk);
    else     repeat ($urandom_range(0, 3 * CPB)) @(posedge clk);
    #1;
  endtask

  task automatic verify(input string tag);
    repeat (4 * CPB) @(posedge clk);
    #1;
    chk({tag, "_count"}, obs_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      chk({tag, "_addr"}, obs_addr[i], exp_addr[i]);
      chk({tag, "_data"}, obs_data[i], exp_data[i]);
    end
    for (int a = 0; a < 16; a++) chk({tag, "_ram"}, 32'(tb_ram[a]), 32'(exp_ram[a]));
    chk({tag, "_done"}, obs_done, exp_done);
    chk({tag, "_err"}, 32'(load_err), 32'(m_err));
    chk({tag, "_halt"}, 32'(cpu_halt), 32'(m_loading));
    obs_addr.delete(); obs_data.delete(); exp_addr.delete(); exp_data.delete();
    obs_done = 0; exp_done = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pm"},   32'(prog_mode), 32'd0);
    chk({tag, "_addr"}, 32'(prog_addr), 32'd0);
    chk({tag, "_data"}, 32'(prog_data), 32'd0);
    chk({tag, "_halt"}, 32'(cpu_halt),  32'd0);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_err"},  32'(load_err),  32'd0);
    chk({tag, "_busy"}, 32'(busy),      32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] img[16];
    for (int a = 0; a < 16; a++) begin
      tb_ram[a] = 8'h00; exp_ram[a] = 8'h00;
    end

    // Reset and idle line
    rst = 1'b1; rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    verify("idle");

    // Sync followed by 0x10..0x1F
    send_byte(SYNC, 1'b1);
    chk("halt_after_sync", 32'(cpu_halt), 32'd1);
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), 1'b1);
    verify("seq_load");

    // Non-sync bytes are ignored, then a load containing sync values as data
    send_byte(8'h3C, 1'b1);
    send_byte(8'hAA, 1'b1);
    verify("no_sync");
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    img[2] = SYNC; img[9] = SYNC;
    send_byte(SYNC, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(img[i], 1'b1);
    verify("sync_as_data");

    // Framing error mid-load aborts after five writes
    send_byte(SYNC, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b0);
    verify("abort");
    send_byte(SYNC, 1'b1);
    chk("err_cleared_by_sync", 32'(load_err), 32'd0);

    // Short glitch during a load must not produce a byte or an error
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
    rx = 1'b0;
    @(posedge clk); #1;
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    chk("glitch_busy", 32'(busy), 32'd0);
    chk("glitch_err", 32'(load_err), 32'd0);
    for (int i = 0; i < 13; i++) send_byte(8'($urandom), 1'b1);
    verify("glitch_load");

    // Reset during the 8th image byte
    send_byte(SYNC, 1'b1);
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b1);
    verify("pre_reset");
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    chk("busy_before_reset", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    rx = 1'b1;
    m_loading = 0; m_err = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2 * CPB) @(posedge clk);
    #1;
    send_byte(SYNC, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b1);
    verify("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader that sits directly upstream of the 16x8 RAM's programming port. It receives an 8N1 UART byte stream on a single input pin and recognises a sync byte, then a 16-byte image. It writes each image byte into RAM via one-cycle `prog_mode` strobes with `prog_addr`/`prog_data` held stable. While a load is in progress it holds the CPU halted, so RAM contents change only under loader control.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Must be ≥ 4 and even.
- `SYNC_BYTE`, default 8'h55: header byte that starts a load.

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `rx`  in  1  UART serial input, idle high, asynchronous to `clk`
- `prog_mode`  out  1  one-cycle RAM write strobe; drives the RAM's `prog_mode`
- `prog_addr`  out  4  RAM write address, valid while `prog_mode`=1
- `prog_data`  out  8  RAM write data; drives the RAM's `w_data` when `prog_mode`=1
- `cpu_halt`  out  1  high from sync-byte acceptance until load completes or aborts
- `load_done`  out  1  one-cycle pulse after the 16th byte is written
- `load_err`  out  1  sticky framing-error flag
- `busy`  out  1  high whenever the UART receiver is not in RX_IDLE

## Operation
- Reset values:
  - `prog_mode`, `cpu_halt`, `load_done`, `load_err`, `busy` = 0.
  - `prog_addr` = 0 and `prog_data` = 0.
  - Synchroniser flops = 1 (idle line).
  - Both FSMs return to their IDLE states.
- `rx` passes through a 2-flop synchroniser. All receiver logic uses the synchronised signal `rx_s`.
- Receiver FSM states are RX_IDLE, RX_START, RX_DATA and RX_STOP. It uses a bit counter `bit_cnt` (3 bits) and a tick counter of width $clog2(CLKS_PER_BIT).
  - RX_IDLE: when `rx_s`=0, go to RX_START and clear the tick counter.
  - RX_START: at tick CLKS_PER_BIT/2-1 (mid start bit), sample `rx_s`. If 0, go to RX_DATA. If 1 (glitch), return to RX_IDLE with no other effect.
  - RX_DATA: sample every CLKS_PER_BIT ticks, LSB first, into a shift register. After bit 7 go to RX_STOP.
  - RX_STOP: sample after CLKS_PER_BIT ticks. If 1, raise `byte_valid` for one cycle. If 0, raise `frame_err` for one cycle. Either way go to RX_IDLE.
- Loader FSM states are L_IDLE, L_LOAD and L_DONE. It uses a 4-bit address counter `wr_addr`.
  - L_IDLE: a `byte_valid` with data == SYNC_BYTE does all of the following, then goes to L_LOAD:
    - sets `cpu_halt`=1 and `wr_addr`=0;
    - clears `load_err`.
  - L_IDLE: any other byte is ignored. A framing error sets `load_err` and the FSM stays in L_IDLE.
  - L_LOAD, on `byte_valid`:
    - next cycle, `prog_mode`=1, `prog_addr`=`wr_addr` and `prog_data`=byte;
    - `wr_addr` increments;
    - if `wr_addr` was 15, go to L_DONE.
  - In L_LOAD, SYNC_BYTE values are treated as ordinary data.
  - L_LOAD, on `frame_err`: abort. Set `load_err`=1, set `cpu_halt`=0, go to L_IDLE. Bytes already written remain in RAM.
  - L_DONE: for exactly one cycle `load_done`=1. In that cycle `cpu_halt` falls to 0. Then go to L_IDLE.
- `wr_addr` never wraps within a load. Exactly 16 strobes occur per successful load, at addresses 0..15 in order.
- `prog_addr` and `prog_data` hold their last values between strobes. Between strobes `prog_mode` is 0, so the RAM's normal `w_en` path is unaffected.
- Reset mid-byte or mid-load:
  - immediate abort;
  - all outputs return to their reset values;
  - a new load requires a new sync byte.

## Timing
- `rx` to `rx_s` latency: 2 cycles.
- `byte_valid` rises in the cycle after the stop-bit sample.
- `prog_mode` rises 1 cycle after `byte_valid`. It stays high exactly 1 cycle, and the RAM captures on that same edge.
- `cpu_halt` rises 1 cycle after the sync byte's `byte_valid`.
- `load_done` is asserted the cycle after the 16th `prog_mode` strobe. `cpu_halt` drops on the same edge.
- Minimum spacing between strobes is 10*CLKS_PER_BIT cycles, fixed by the line rate. No back-pressure exists.
- A falling edge of `rx_s` in RX_STOP after the sample is handled as a new start bit: RX_IDLE is entered and the edge detected in the next cycle.

## Test plan
- Reset with `rx`=1, CLKS_PER_BIT=4: all outputs are 0 and `busy`=0. Hold for 100 cycles and confirm no strobe.
- Send 0x55 followed by bytes 0x10..0x1F:
  - `cpu_halt` is high throughout;
  - 16 `prog_mode` pulses occur with (addr,data) = (0,0x10)..(15,0x1F);
  - a single `load_done` pulse follows;
  - a RAM model read-back matches.
- Send 0x3C and 0xAA with no sync: no strobe and `cpu_halt` stays 0. Then send 0x55 followed by 16 bytes that include 0x55: all are written as data.
- Send 0x55, five good bytes, then one byte with stop bit 0:
  - `load_err`=1 and `cpu_halt`=0;
  - addresses 0..4 are written and nothing more;
  - a subsequent 0x55 clears `load_err`.
- Drive a low glitch on `rx` shorter than CLKS_PER_BIT/2: the receiver returns to RX_IDLE, with no `byte_valid` and no `frame_err`.
- Assert `rst` during the 8th data byte's data bits: outputs reset immediately. A full new 0x55 plus 16-byte load then writes addresses 0..15.
